// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start/done handshake frames each operation; results stay registered until the next one.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   aSh_q, aSh_d;
    logic [WIDTH-1:0]   bSh_q, bSh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               aMsb_q, aMsb_d;
    logic               bMsb_q, bMsb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               dBit;
    logic               brNext;
    logic [WIDTH-1:0]   resShift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            aMsb_q  <= 1'b0;
            bMsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            aMsb_q  <= aMsb_d;
            bMsb_q  <= bMsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // One full-subtractor bit slice; the difference bit enters the result from the MSB side.
    always_comb begin
        dBit     = aSh_q[0] ^ bSh_q[0] ^ br_q;
        brNext   = (~aSh_q[0] & bSh_q[0]) | (~(aSh_q[0] ^ bSh_q[0]) & br_q);
        resShift = {dBit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        aMsb_d  = aMsb_q;
        bMsb_d  = bMsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    aMsb_d  = a[WIDTH-1];
                    bMsb_d  = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d = aSh_q >> 1;
                bSh_d = bSh_q >> 1;
                res_d = resShift;
                br_d  = brNext;
                cnt_d = cnt_q + 1'b1;
                // Operand MSBs were captured at start because the shift registers no longer hold them.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = resShift;
                    bout_d  = brNext;
                    ovf_d   = (aMsb_q != bMsb_q) & (dBit != aMsb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): arithmetic reference model
// checked every cycle, plus hand-computed expectations for the directed cases.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checkEn = 0;

    // Reference model state: position in the operation timeline and the held results.
    int           mPos = 0;
    logic [W-1:0] mA, mB;
    logic         mBin;
    logic [W-1:0] mDiff = '0;
    logic         mBout = 1'b0;
    logic         mOvf = 1'b0;
    int           acceptCyc[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer arithmetic: unsigned for diff/bout, signed range test for overflow.
    function automatic void computeExpect(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                          input logic ibin, output logic [W-1:0] eDiff,
                                          output logic eBout, output logic eOvf);
        int raw;
        int sa;
        int sb;
        int sr;
        raw   = int'(ia) - int'(ib) - int'(ibin);
        eDiff = W'(raw & ((1 << W) - 1));
        eBout = (raw < 0);
        sa    = ia[W-1] ? int'(ia) - (1 << W) : int'(ia);
        sb    = ib[W-1] ? int'(ib) - (1 << W) : int'(ib);
        sr    = sa - sb - int'(ibin);
        eOvf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model advances on the same edges the DUT samples; inputs are only driven on negedges.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mPos  = 0;
            mDiff = '0;
            mBout = 1'b0;
            mOvf  = 1'b0;
        end else if (mPos == 0) begin
            if (start) begin
                mA   = a;
                mB   = b;
                mBin = bin;
                mPos = 1;
                acceptCyc.push_back(cyc);
            end
        end else if (mPos < W) begin
            mPos++;
        end else if (mPos == W) begin
            computeExpect(mA, mB, mBin, mDiff, mBout, mOvf);
            mPos = W + 1;
        end else begin
            mPos = 0;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", int'(busy), int'(mPos >= 1 && mPos <= W));
            checkOutput("done", int'(done), int'(mPos == W + 1));
            checkOutput("diff", int'(diff), int'(mDiff));
            checkOutput("bout", int'(bout), int'(mBout));
            checkOutput("ovf", int'(ovf), int'(mOvf));
            checkOutput("busy_done_overlap", int'(busy & done), 0);
        end
    end

    // Start one operation, scramble the operands afterwards, wait for done and check literals.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                                 input logic [W-1:0] eDiff, input logic eBout, input logic eOvf);
        int busyCnt;
        bit seen;
        logic [W-1:0] pDiff;
        logic pBout, pOvf;
        busyCnt = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        a = ia;
        b = ib;
        bin = ibin;
        @(negedge clk);
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        bin = ~ibin;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busyCnt++;
            @(negedge clk);
        end
        if (!seen) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 20 cycles");
        end else begin
            checkOutput("lit_busy_cycles", busyCnt, W);
            checkOutput("lit_diff", int'(diff), int'(eDiff));
            checkOutput("lit_bout", int'(bout), int'(eBout));
            checkOutput("lit_ovf", int'(ovf), int'(eOvf));
            computeExpect(ia, ib, ibin, pDiff, pBout, pOvf);
            checkOutput("model_pin_diff", int'(pDiff), int'(eDiff));
            checkOutput("model_pin_bout", int'(pBout), int'(eBout));
            checkOutput("model_pin_ovf", int'(pOvf), int'(eOvf));
        end
    endtask

    initial begin
        logic [W-1:0] opA [10];
        logic [W-1:0] opB [10];
        int first;
        int second;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_diff", int'(diff), 0);
        checkOutput("reset_bout", int'(bout), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        checkEn = 1;

        applyStimulus(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
        applyStimulus(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b1);

        // Start held high with operands changing every cycle; only IDLE-time starts count.
        for (int i = 0; i < 10; i++) begin
            opA[i] = W'(3 * i + 5);
            opB[i] = W'(7 * i + 2);
        end
        acceptCyc.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b1;
            a = opA[i];
            b = opB[i];
            bin = i[0];
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        checkOutput("handshake_accepts", acceptCyc.size(), 2);
        if (acceptCyc.size() == 2) begin
            first = acceptCyc[0];
            second = acceptCyc[1];
            checkOutput("handshake_spacing", second - first, W + 2);
        end

        // Reset in the middle of RUN discards the operation without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a = 4'b1010;
        b = 4'b0011;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrun_busy", int'(busy), 0);
        checkOutput("midrun_done", int'(done), 0);
        checkOutput("midrun_diff", int'(diff), 0);
        checkOutput("midrun_bout", int'(bout), 0);
        checkOutput("midrun_ovf", int'(ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            checkOutput("midrun_no_done", int'(done), 0);
        end
        applyStimulus(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
